// File: rtl/knap_sweep_ctrl.sv
// Exhaustive knapsack search: issues every selection mask once per clock through a
// two-stage sum/compare pipeline and keeps the best feasible mask and a feasible count.
module knap_sweep_ctrl #(
   parameter int N_ITEMS = 12,
   parameter int W       = 8,
   parameter int IW      = $clog2(N_ITEMS),
   parameter int S       = W + IW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [IW-1:0]      cfg_idx,
   input  logic [W-1:0]       cfg_value,
   input  logic [W-1:0]       cfg_weight,
   input  logic [W-1:0]       cfg_volume,
   input  logic [W-1:0]       min_value,
   input  logic [W-1:0]       max_weight,
   input  logic [W-1:0]       max_volume,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               best_valid,
   output logic [N_ITEMS-1:0] best_mask,
   output logic [S-1:0]       best_value,
   output logic [N_ITEMS:0]   feasible_count
);
   localparam int CW = N_ITEMS + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [W-1:0]       tab_val_q [N_ITEMS];
   logic [W-1:0]       tab_val_d [N_ITEMS];
   logic [W-1:0]       tab_wt_q  [N_ITEMS];
   logic [W-1:0]       tab_wt_d  [N_ITEMS];
   logic [W-1:0]       tab_vol_q [N_ITEMS];
   logic [W-1:0]       tab_vol_d [N_ITEMS];
   logic [W-1:0]       min_val_q, min_val_d;
   logic [W-1:0]       max_wt_q, max_wt_d;
   logic [W-1:0]       max_vol_q, max_vol_d;
   logic               s1_valid_q, s1_valid_d;
   logic [N_ITEMS-1:0] s1_mask_q, s1_mask_d;
   logic [S-1:0]       s1_val_q, s1_val_d;
   logic [S-1:0]       s1_wt_q, s1_wt_d;
   logic [S-1:0]       s1_vol_q, s1_vol_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               best_valid_q, best_valid_d;
   logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
   logic [S-1:0]       best_value_q, best_value_d;
   logic [CW-1:0]      count_q, count_d;
   logic               idle_s, accept_s, feasible_s;

   // Next-state logic: table writes, FSM, stage-1 sums and stage-2 result update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tab_val_d    = tab_val_q;
      tab_wt_d     = tab_wt_q;
      tab_vol_d    = tab_vol_q;
      min_val_d    = min_val_q;
      max_wt_d     = max_wt_q;
      max_vol_d    = max_vol_q;
      best_valid_d = best_valid_q;
      best_mask_d  = best_mask_q;
      best_value_d = best_value_q;
      count_d      = count_q;

      idle_s   = (state_q == ST_IDLE) || (state_q == ST_DONE);
      accept_s = idle_s && start;

      // The table only changes outside a sweep, so every mask sees the same entries.
      if (idle_s && cfg_we && (32'(cfg_idx) < N_ITEMS)) begin
         tab_val_d[cfg_idx] = cfg_value;
         tab_wt_d[cfg_idx]  = cfg_weight;
         tab_vol_d[cfg_idx] = cfg_volume;
      end else begin
         tab_val_d = tab_val_q;
      end

      s1_valid_d = (state_q == ST_SWEEP);
      s1_mask_d  = cnt_q[N_ITEMS-1:0];
      s1_val_d   = '0;
      s1_wt_d    = '0;
      s1_vol_d   = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         s1_val_d = s1_val_d + (cnt_q[i] ? S'(tab_val_q[i]) : S'(0));
         s1_wt_d  = s1_wt_d  + (cnt_q[i] ? S'(tab_wt_q[i])  : S'(0));
         s1_vol_d = s1_vol_d + (cnt_q[i] ? S'(tab_vol_q[i]) : S'(0));
      end

      feasible_s = s1_valid_q && (s1_val_q >= S'(min_val_q)) &&
                   (s1_wt_q <= S'(max_wt_q)) && (s1_vol_q <= S'(max_vol_q));

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s) begin
               state_d = ST_SWEEP;
               cnt_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_SWEEP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d[N_ITEMS]) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_SWEEP;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase

      if (accept_s) begin
         min_val_d    = min_value;
         max_wt_d     = max_weight;
         max_vol_d    = max_volume;
         best_valid_d = 1'b0;
         best_mask_d  = '0;
         best_value_d = '0;
         count_d      = '0;
      end else if (feasible_s) begin
         count_d = count_q + CW'(1);
         // Strict compare: on a tie the earlier (lower) mask is kept.
         if (!best_valid_q || (s1_val_q > best_value_q)) begin
            best_valid_d = 1'b1;
            best_mask_d  = s1_mask_q;
            best_value_d = s1_val_q;
         end else begin
            best_valid_d = best_valid_q;
         end
      end else begin
         count_d = count_q;
      end

      busy_d = (state_d == ST_SWEEP) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // State, table, limit, pipeline and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         for (int i = 0; i < N_ITEMS; i++) begin
            tab_val_q[i] <= '0;
            tab_wt_q[i]  <= '0;
            tab_vol_q[i] <= '0;
         end
         min_val_q    <= '0;
         max_wt_q     <= '0;
         max_vol_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_mask_q    <= '0;
         s1_val_q     <= '0;
         s1_wt_q      <= '0;
         s1_vol_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         best_valid_q <= 1'b0;
         best_mask_q  <= '0;
         best_value_q <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         for (int i = 0; i < N_ITEMS; i++) begin
            tab_val_q[i] <= tab_val_d[i];
            tab_wt_q[i]  <= tab_wt_d[i];
            tab_vol_q[i] <= tab_vol_d[i];
         end
         min_val_q    <= min_val_d;
         max_wt_q     <= max_wt_d;
         max_vol_q    <= max_vol_d;
         s1_valid_q   <= s1_valid_d;
         s1_mask_q    <= s1_mask_d;
         s1_val_q     <= s1_val_d;
         s1_wt_q      <= s1_wt_d;
         s1_vol_q     <= s1_vol_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         best_valid_q <= best_valid_d;
         best_mask_q  <= best_mask_d;
         best_value_q <= best_value_d;
         count_q      <= count_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign best_valid     = best_valid_q;
   assign best_mask      = best_mask_q;
   assign best_value     = best_value_q;
   assign feasible_count = count_q;

endmodule

// File: tb/tb_knap_sweep_ctrl.sv
// Bench for knap_sweep_ctrl: fixed vector table, randomized tables checked against a
// brute-force reference, and hand sequences for busy-time writes, start-at-done and reset.
module tb_knap_sweep_ctrl;
   localparam int N  = 12;
   localparam int W  = 8;
   localparam int IW = 4;
   localparam int S  = 12;
   localparam int DONE_EDGES = 4097;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [W-1:0]  cfg_value = '0, cfg_weight = '0, cfg_volume = '0;
   logic [W-1:0]  min_value = '0, max_weight = '0, max_volume = '0;
   logic          start = 1'b0;
   logic          busy, done, best_valid;
   logic [N-1:0]  best_mask;
   logic [S-1:0]  best_value;
   logic [N:0]    feasible_count;

   int tests = 0;
   int fails = 0;

   knap_sweep_ctrl dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_value(cfg_value), .cfg_weight(cfg_weight), .cfg_volume(cfg_volume),
      .min_value(min_value), .max_weight(max_weight), .max_volume(max_volume),
      .start(start), .busy(busy), .done(done), .best_valid(best_valid),
      .best_mask(best_mask), .best_value(best_value), .feasible_count(feasible_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0][W-1:0] val;
      logic [N-1:0][W-1:0] wt;
      logic [N-1:0][W-1:0] vol;
      logic [W-1:0]        minv;
      logic [W-1:0]        maxw;
      logic [W-1:0]        maxv;
      logic [N:0]          cnt;
      logic [N-1:0]        mask;
      logic [S-1:0]        bval;
      logic                valid;
   } vec_t;

   vec_t vecs [5];
   logic [N-1:0][W-1:0] cur_val, cur_wt, cur_vol;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input int v, input int w, input int o);
      cfg_idx    = IW'(idx);
      cfg_value  = W'(v);
      cfg_weight = W'(w);
      cfg_volume = W'(o);
      cfg_we     = 1'b1;
      tick();
      cfg_we     = 1'b0;
   endtask

   // Loads the whole table, then writes out-of-range indices that must be ignored.
   task automatic load_table();
      for (int i = 0; i < N; i++) wr(i, cur_val[i], cur_wt[i], cur_vol[i]);
      for (int i = N; i < 16; i++) wr(i, 255, 0, 0);
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (done !== 1'b1 && edges < 5000) begin
         tick();
         edges++;
      end
   endtask

   task automatic run(input string tag, output int edges);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_on_start"}, int'(busy), 1);
      check({tag, "_done_clr_on_start"}, int'(done), 0);
      wait_done(edges);
   endtask

   task automatic check_res(input string tag, input int edges, input int ec, input int em,
                            input int ev, input int evalid);
      check({tag, "_done_edge"}, edges, DONE_EDGES);
      check({tag, "_busy_at_done"}, int'(busy), 0);
      check({tag, "_count"}, int'(feasible_count), ec);
      check({tag, "_mask"}, int'(best_mask), em);
      check({tag, "_value"}, int'(best_value), ev);
      check({tag, "_valid"}, int'(best_valid), evalid);
   endtask

   // Brute-force reference: enumerate every subset with plain integer sums.
   task automatic model(input int mv, input int mw, input int mo, output int cnt,
                        output int bmask, output int bval, output int bvalid);
      cnt = 0; bmask = 0; bval = 0; bvalid = 0;
      for (int m = 0; m < (1 << N); m++) begin
         int sv, sw, so;
         sv = 0; sw = 0; so = 0;
         for (int i = 0; i < N; i++) begin
            if (((m >> i) & 1) == 1) begin
               sv += int'(cur_val[i]);
               sw += int'(cur_wt[i]);
               so += int'(cur_vol[i]);
            end
         end
         if (sv >= mv && sw <= mw && so <= mo) begin
            cnt++;
            if (bvalid == 0 || sv > bval) begin
               bvalid = 1; bmask = m; bval = sv;
            end
         end
      end
   endtask

   task automatic use_vec(input int k);
      cur_val = vecs[k].val;
      cur_wt  = vecs[k].wt;
      cur_vol = vecs[k].vol;
      min_value  = vecs[k].minv;
      max_weight = vecs[k].maxw;
      max_volume = vecs[k].maxv;
   endtask

   initial begin
      int edges, ec, em, ev, evalid;

      for (int k = 0; k < 5; k++) vecs[k] = '0;
      vecs[0].cnt = 13'd4096; vecs[0].valid = 1'b1;
      vecs[1].val[3] = 8'd20; vecs[1].wt[3] = 8'd18; vecs[1].vol[3] = 8'd4;
      vecs[1].minv = 8'd10; vecs[1].maxw = 8'd60; vecs[1].maxv = 8'd60;
      vecs[1].cnt = 13'd2048; vecs[1].mask = 12'h008; vecs[1].bval = 12'd20; vecs[1].valid = 1'b1;
      for (int i = 0; i < N; i++) vecs[2].val[i] = 8'd10;
      vecs[2].minv = 8'd255; vecs[2].maxw = 8'd255; vecs[2].maxv = 8'd255;
      for (int i = 0; i < N; i++) vecs[3].val[i] = 8'd30;
      vecs[3].minv = 8'd255; vecs[3].maxw = 8'd255; vecs[3].maxv = 8'd255;
      vecs[3].cnt = 13'd299; vecs[3].mask = 12'hFFF; vecs[3].bval = 12'd360; vecs[3].valid = 1'b1;
      vecs[4].val[0] = 8'd5; vecs[4].wt[0] = 8'd40; vecs[4].val[1] = 8'd5; vecs[4].wt[1] = 8'd40;
      vecs[4].minv = 8'd5; vecs[4].maxw = 8'd60; vecs[4].maxv = 8'd60;
      vecs[4].cnt = 13'd2048; vecs[4].mask = 12'h001; vecs[4].bval = 12'd5; vecs[4].valid = 1'b1;

      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_valid", int'(best_valid), 0);
      check("rst_mask", int'(best_mask), 0);
      check("rst_value", int'(best_value), 0);
      check("rst_count", int'(feasible_count), 0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 5; k++) begin
         use_vec(k);
         load_table();
         run($sformatf("vec%0d", k), edges);
         check_res($sformatf("vec%0d", k), edges, int'(vecs[k].cnt), int'(vecs[k].mask),
                   int'(vecs[k].bval), int'(vecs[k].valid));
      end

      // Random tables; the last entry is written in the same cycle as start.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            cur_val[i] = W'($urandom_range(0, 255));
            cur_wt[i]  = W'($urandom_range(0, 80));
            cur_vol[i] = W'($urandom_range(0, 80));
         end
         min_value  = W'($urandom_range(0, 255));
         max_weight = W'($urandom_range(60, 255));
         max_volume = W'($urandom_range(60, 255));
         for (int i = 0; i < N - 1; i++) wr(i, cur_val[i], cur_wt[i], cur_vol[i]);
         cfg_idx = IW'(N - 1);
         cfg_value = cur_val[N-1]; cfg_weight = cur_wt[N-1]; cfg_volume = cur_vol[N-1];
         cfg_we = 1'b1;
         start  = 1'b1;
         tick();
         cfg_we = 1'b0;
         start  = 1'b0;
         check($sformatf("rnd%0d_busy_on_start", r), int'(busy), 1);
         wait_done(edges);
         model(int'(min_value), int'(max_weight), int'(max_volume), ec, em, ev, evalid);
         check_res($sformatf("rnd%0d", r), edges, ec, em, ev, evalid);
      end

      // Write, start and limit changes during a sweep must all be ignored.
      use_vec(1);
      load_table();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (49) tick();
      cfg_idx = 4'd3; cfg_value = 8'd0; cfg_weight = 8'd255; cfg_volume = 8'd255;
      min_value = 8'd0; max_weight = 8'd0; max_volume = 8'd0;
      cfg_we = 1'b1;
      start  = 1'b1;
      tick();
      cfg_we = 1'b0;
      start  = 1'b0;
      wait_done(edges);
      check_res("busy_dist", edges + 50, 2048, 12'h008, 20, 1);

      // start held across done's rising edge is taken one cycle later; then reset mid-sweep.
      use_vec(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4096) tick();
      check("sad_done_before", int'(done), 0);
      start = 1'b1;
      tick();
      check("sad_done_rise", int'(done), 1);
      check("sad_busy_fall", int'(busy), 0);
      check("sad_count_final", int'(feasible_count), 2048);
      tick();
      start = 1'b0;
      check("sad_restart_busy", int'(busy), 1);
      check("sad_restart_done", int'(done), 0);
      check("sad_restart_count", int'(feasible_count), 0);
      check("sad_restart_valid", int'(best_valid), 0);
      repeat (98) tick();
      check("mid_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check("mid_rst_valid", int'(best_valid), 0);
      check("mid_rst_mask", int'(best_mask), 0);
      check("mid_rst_value", int'(best_value), 0);
      check("mid_rst_count", int'(feasible_count), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("post_rst_idle_busy", int'(busy), 0);
      check("post_rst_idle_done", int'(done), 0);
      // A cleared table makes every mask feasible even with zero ceilings.
      min_value = 8'd0; max_weight = 8'd0; max_volume = 8'd0;
      run("post_rst", edges);
      check_res("post_rst", edges, 4096, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
